// File: rtl/gpio_cfg_sequencer_pkg.sv
// Shared definitions for the GPIO serial configuration sequencer: state encoding,
// default word width and the bit layout of one pad's configuration word.
package gpio_cfg_sequencer_pkg;

   localparam int unsigned CfgBitsDefault = 13;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFetch,
      StShift,
      StLoad,
      StFin
   } state_e;

   // Field offsets within a configuration word, dm[2:0] occupying the top bits.
   localparam int unsigned CfgAnalogPolIdx = 0;
   localparam int unsigned CfgAnalogSelIdx = 1;
   localparam int unsigned CfgAnalogEnIdx  = 2;
   localparam int unsigned CfgHoldoverIdx  = 3;
   localparam int unsigned CfgSlowSelIdx   = 4;
   localparam int unsigned CfgVtripSelIdx  = 5;
   localparam int unsigned CfgIbModeSelIdx = 6;
   localparam int unsigned CfgInpDisIdx    = 7;
   localparam int unsigned CfgEnhIdx       = 8;
   localparam int unsigned CfgOebIdx       = 9;
   localparam int unsigned CfgDmLsbIdx     = 10;
   localparam int unsigned CfgDmWidth      = 3;

endpackage

// File: rtl/gpio_cfg_tick.sv
// Serial-timing tick: pulses on every Div-th enabled cycle, restarting its count
// whenever it is disabled or explicitly cleared.
module gpio_cfg_tick #(
   parameter int unsigned Div = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   logic [7:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == 8'(Div - 1));

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (clr_i || !en_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Loads every pad's configuration word into the serial GPIO chain: clear the chain,
// then fetch/shift words from the highest pad down to pad 0, then strobe the latch.
module gpio_cfg_sequencer
   import gpio_cfg_sequencer_pkg::*;
#(
   parameter int unsigned NUM_PADS = 38,
   parameter int unsigned CFG_BITS = CfgBitsDefault,
   parameter int unsigned CLK_DIV  = 2
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
   input  logic [CFG_BITS-1:0]         cfg_data,
   output logic                        serial_clock,
   output logic                        serial_load,
   output logic                        serial_data,
   output logic                        serial_resetn
);

   localparam int unsigned AddrW = $clog2(NUM_PADS);
   localparam int unsigned BitW  = $clog2(CFG_BITS);

   state_e              state_q, state_d;
   logic                phase_q, phase_d;
   logic                sclk_q, sclk_d;
   logic [BitW-1:0]     bit_q, bit_d;
   logic [AddrW-1:0]    pad_q, pad_d;
   logic [CFG_BITS-1:0] word_q, word_d;
   logic                tick, tick_en, tick_clr;

   assign tick_en  = (state_q == StClear) || (state_q == StShift) || (state_q == StLoad);
   assign tick_clr = (state_d != state_q);

   gpio_cfg_tick #(
      .Div (CLK_DIV)
   ) u_tick (
      .clk_i  (clk),
      .rst_ni (resetn),
      .en_i   (tick_en),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   // phase_q: second half of CLEAR/LOAD, data-capture cycle of FETCH, high half of a bit.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      sclk_d  = sclk_q;
      bit_d   = bit_q;
      pad_d   = pad_q;
      word_d  = word_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StClear;
         end
         StClear: begin
            if (tick) begin
               phase_d = ~phase_q;
               if (phase_q) state_d = StFetch;
            end
         end
         StFetch: begin
            phase_d = 1'b1;
            if (phase_q) begin
               word_d  = cfg_data;
               bit_d   = BitW'(CFG_BITS - 1);
               state_d = StShift;
            end
         end
         StShift: begin
            if (tick) begin
               phase_d = ~phase_q;
               sclk_d  = ~phase_q;
               // The word is shifted out on the falling edge, so it is all-zero once done.
               if (phase_q) begin
                  word_d = word_q << 1;
                  if (bit_q == '0) begin
                     if (pad_q == '0) begin
                        state_d = StLoad;
                     end else begin
                        pad_d   = pad_q - 1'b1;
                        state_d = StFetch;
                     end
                  end else begin
                     bit_d = bit_q - 1'b1;
                  end
               end
            end
         end
         StLoad: begin
            if (tick) begin
               phase_d = ~phase_q;
               if (phase_q) state_d = StFin;
            end
         end
         StFin: begin
            pad_d   = AddrW'(NUM_PADS - 1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) phase_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         phase_q <= 1'b0;
         sclk_q  <= 1'b0;
         bit_q   <= '0;
         pad_q   <= AddrW'(NUM_PADS - 1);
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
         bit_q   <= bit_d;
         pad_q   <= pad_d;
         word_q  <= word_d;
      end
   end

   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StFin);
   assign serial_load   = (state_q == StLoad);
   assign serial_resetn = (state_q != StClear);
   assign serial_clock  = sclk_q;
   assign serial_data   = word_q[CFG_BITS-1];
   assign cfg_addr      = pad_q;

endmodule
